// File: rtl/venc_pkg.sv
// Shared types and constants for the convolutional-encoder frame sequencer.
package venc_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    DATA = 3'd2,
    TAIL = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam int K        = 3;
  localparam int TAIL_LEN = K - 1;

  // Width of a counter that must hold the values 0..n without wrapping.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/venc_bit_serializer.sv
// Payload shift register, coded-bit phase toggle and payload bit counter
// for the frame sequencer; sequencing decisions live in venc_frame_ctrl.
module venc_bit_serializer #(
  parameter int DATA_W = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clear,
  input  logic                                  load,
  input  logic                                  shift,
  input  logic                                  advance,
  input  logic [DATA_W-1:0]                     load_data,
  output logic                                  msb_d,
  output logic                                  phase_d,
  output logic                                  phase_q,
  output logic [venc_pkg::cnt_w(DATA_W)-1:0]    bit_cnt_q
);
  import venc_pkg::*;

  localparam int CNT_W = cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_d;
  logic [CNT_W-1:0]  bit_cnt_d;

  // clear beats load; the counter saturates at DATA_W instead of wrapping
  always_comb begin
    shreg_d   = shreg_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    if (clear) begin
      shreg_d   = '0;
      phase_d   = 1'b0;
      bit_cnt_d = '0;
    end else if (load) begin
      shreg_d   = load_data;
      phase_d   = 1'b0;
      bit_cnt_d = '0;
    end else begin
      if (advance) begin
        phase_d = ~phase_q;
      end else begin
        phase_d = phase_q;
      end
      if (shift) begin
        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
        if (bit_cnt_q != CNT_MAX) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end else begin
        shreg_d = shreg_q;
      end
    end
    msb_d = shreg_d[DATA_W-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q   <= '0;
      phase_q   <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/venc_frame_ctrl.sv
// Frame sequencer feeding a rate-1/2 serial convolutional encoder, two cycles per bit.
// Define VENC_TAIL_EN to append K-1 zero tail bits that return the trellis to state 0.
module venc_frame_ctrl #(
  parameter int DATA_W = 8,
  parameter int K      = venc_pkg::K
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              abort,
  output logic              enc_reset,
  output logic              enc_in,
  output logic              enc_phase,
  output logic              busy,
  output logic              frame_done
);
  import venc_pkg::*;

  localparam int CNT_W = cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_e           state_q, state_d;
  logic             load_s, shift_s, clear_s, advance_s, abort_s;
  logic             msb_d, phase_d, phase_q;
  logic [CNT_W-1:0] bit_cnt_q;

  logic in_ready_q,   in_ready_d;
  logic enc_reset_q,  enc_reset_d;
  logic enc_in_q,     enc_in_d;
  logic enc_phase_q,  enc_phase_d;
  logic busy_q,       busy_d;
  logic frame_done_q, frame_done_d;

`ifdef VENC_TAIL_EN
  localparam int TAIL_N = K - 1;
  localparam int TW     = cnt_w(TAIL_N);
  localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL_N - 1);
  logic [TW-1:0] tail_cnt_q, tail_cnt_d;
`endif

  venc_bit_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk       (Clock),
    .reset     (reset),
    .clear     (clear_s),
    .load      (load_s),
    .shift     (shift_s),
    .advance   (advance_s),
    .load_data (in_data),
    .msb_d     (msb_d),
    .phase_d   (phase_d),
    .phase_q   (phase_q),
    .bit_cnt_q (bit_cnt_q)
  );

  // Handshake uses the registered in_ready so acceptance matches what the source saw.
  always_comb begin
    state_d   = state_q;
    load_s    = 1'b0;
    shift_s   = 1'b0;
    clear_s   = 1'b0;
    advance_s = 1'b0;
    abort_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = CLR;
          load_s  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      CLR: state_d = DATA;
      DATA: begin
        advance_s = 1'b1;
        if (phase_q) begin
          shift_s = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef VENC_TAIL_EN
            state_d = TAIL;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      TAIL: begin
`ifdef VENC_TAIL_EN
        advance_s = 1'b1;
        if (phase_q && (tail_cnt_q == TAIL_LAST)) begin
          state_d = DONE;
        end else begin
          state_d = TAIL;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      abort_s   = 1'b1;
      state_d   = IDLE;
      load_s    = 1'b0;
      shift_s   = 1'b0;
      advance_s = 1'b0;
      clear_s   = 1'b1;
    end else begin
      abort_s = 1'b0;
    end
  end

`ifdef VENC_TAIL_EN
  always_comb begin
    tail_cnt_d = tail_cnt_q;
    if (load_s || clear_s) begin
      tail_cnt_d = '0;
    end else if ((state_q == TAIL) && phase_q) begin
      tail_cnt_d = tail_cnt_q + TW'(1);
    end else begin
      tail_cnt_d = tail_cnt_q;
    end
  end
`endif

  // Outputs are the registered image of the next state; an abort looks like a 1-cycle reset.
  always_comb begin
    in_ready_d   = (state_d == IDLE) && !abort_s;
    enc_reset_d  = (state_d == CLR) || abort_s;
    enc_in_d     = 1'b0;
    enc_phase_d  = 1'b0;
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == DONE);
    if (state_d == DATA) begin
      enc_in_d = msb_d;
    end else begin
      enc_in_d = 1'b0;
    end
    if ((state_d == DATA) || (state_d == TAIL)) begin
      enc_phase_d = phase_d;
    end else begin
      enc_phase_d = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      enc_reset_q  <= 1'b1;
      enc_in_q     <= 1'b0;
      enc_phase_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef VENC_TAIL_EN
      tail_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      enc_reset_q  <= enc_reset_d;
      enc_in_q     <= enc_in_d;
      enc_phase_q  <= enc_phase_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef VENC_TAIL_EN
      tail_cnt_q   <= tail_cnt_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign enc_reset  = enc_reset_q;
  assign enc_in     = enc_in_q;
  assign enc_phase  = enc_phase_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
